mm_job_sequencer: RTL and testbench

Host-side initiator for the matrix-multiply controller. It queues job descriptors (A/B/P base addresses and k/m/n dimensions) from the host register interface in a small FIFO. For each job it drives the controller's start/address/dimension inputs, then waits for the controller's one-cycle `valid` completion pulse. It counts completions, raises a completion interrupt pulse, and flags malformed descriptors and hung jobs.

---
 rtl/mm_job_sequencer_pkg.sv | 25 ++
 rtl/mm_job_sequencer_job_fifo.sv | 60 ++++++
 rtl/mm_job_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mm_job_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_job_sequencer_pkg.sv
// Shared definitions for the matrix-multiply job sequencer: FSM encodings,
// error bit positions and the default controller address width.
package mm_job_sequencer_pkg;

    // Address width of the matrix-multiply controller's base-address ports.
    localparam int SEQ_ADDR_WIDTH = 16;

    localparam int ERR_BADDESC = 0;
    localparam int ERR_TMO     = 1;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_GAP   = 2'd3
    } seq_state_t;

    // A descriptor with any zero dimension would stall the controller.
    function automatic logic desc_ok(input logic [3:0] k,
                                     input logic [3:0] m,
                                     input logic [3:0] n);
        return (k != 4'd0) && (m != 4'd0) && (n != 4'd0);
    endfunction

endpackage

// File: rtl/mm_job_sequencer_job_fifo.sv
// Synchronous descriptor FIFO with registered occupancy, full and empty flags.
// Push and pop may occur in the same cycle; DEPTH must be a power of two.
module job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign rdata      = mem[rd_ptr];

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/mm_job_sequencer.sv
// Host-side job sequencer for the matrix-multiply controller: queues
// descriptors, issues them one at a time and tracks completion, timeouts and errors.
module mm_job_sequencer
    import mm_job_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter int TMO_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]     cmd_base_addra_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_base_addrb_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_base_addrp_i,
    input  logic [3:0]                cmd_k_i,
    input  logic [3:0]                cmd_m_i,
    input  logic [3:0]                cmd_n_i,
    output logic                      start_o,
    output logic [ADDR_WIDTH-1:0]     base_addra_o,
    output logic [ADDR_WIDTH-1:0]     base_addrb_o,
    output logic [ADDR_WIDTH-1:0]     base_addrp_o,
    output logic [3:0]                k_o,
    output logic [3:0]                m_o,
    output logic [3:0]                n_o,
    input  logic                      valid_i,
    input  logic [TMO_W-1:0]          timeout_i,
    output logic                      busy_o,
    output logic [$clog2(DEPTH):0]    pending_o,
    output logic [7:0]                done_cnt_o,
    output logic                      irq_o,
    output logic [1:0]                err_o,
    input  logic                      err_clr_i
);

    localparam int DESC_W = 3*ADDR_WIDTH + 12;

    seq_state_t              state;
    logic [TMO_W-1:0]        wait_cnt;
    logic                    handshake;
    logic                    push;
    logic                    pop;
    logic                    bad_desc;
    logic                    tmo_hit;
    logic                    full;
    logic                    empty;
    logic [1:0]              err_set;
    logic [DESC_W-1:0]       wdata;
    logic [DESC_W-1:0]       head;
    logic [ADDR_WIDTH-1:0]   head_a;
    logic [ADDR_WIDTH-1:0]   head_b;
    logic [ADDR_WIDTH-1:0]   head_p;
    logic [3:0]              head_k;
    logic [3:0]              head_m;
    logic [3:0]              head_n;

    assign cmd_ready_o = !full;
    assign handshake   = cmd_valid_i && cmd_ready_o;
    assign push        = handshake && desc_ok(cmd_k_i, cmd_m_i, cmd_n_i);
    assign bad_desc    = handshake && !desc_ok(cmd_k_i, cmd_m_i, cmd_n_i);
    assign pop         = (state == SEQ_ISSUE);

    assign wdata = {cmd_base_addra_i, cmd_base_addrb_i, cmd_base_addrp_i,
                    cmd_k_i, cmd_m_i, cmd_n_i};
    assign {head_a, head_b, head_p, head_k, head_m, head_n} = head;

    // A timeout of zero disables the watchdog entirely.
    assign tmo_hit = (timeout_i != '0) && (wait_cnt == timeout_i - TMO_W'(1));

    job_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .count (pending_o),
        .full  (full),
        .empty (empty)
    );

    // A completion on the timeout cycle takes precedence over the timeout.
    always_comb begin
        err_set              = 2'b00;
        err_set[ERR_BADDESC] = bad_desc;
        err_set[ERR_TMO]     = (state == SEQ_WAIT) && !valid_i && tmo_hit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 2'b00;
        end else begin
            err_o <= (err_o & ~{2{err_clr_i}}) | err_set;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= SEQ_IDLE;
            wait_cnt     <= '0;
            start_o      <= 1'b0;
            busy_o       <= 1'b0;
            irq_o        <= 1'b0;
            done_cnt_o   <= 8'd0;
            base_addra_o <= '0;
            base_addrb_o <= '0;
            base_addrp_o <= '0;
            k_o          <= 4'd0;
            m_o          <= 4'd0;
            n_o          <= 4'd0;
        end else begin
            start_o <= 1'b0;
            irq_o   <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (!empty) begin
                        base_addra_o <= head_a;
                        base_addrb_o <= head_b;
                        base_addrp_o <= head_p;
                        k_o          <= head_k;
                        m_o          <= head_m;
                        n_o          <= head_n;
                        start_o      <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (valid_i) begin
                        done_cnt_o <= done_cnt_o + 8'd1;
                        irq_o      <= 1'b1;
                        state      <= SEQ_GAP;
                    end else if (tmo_hit) begin
                        state <= SEQ_GAP;
                    end else begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                    end
                end
                SEQ_GAP: begin
                    // Lets the controller finish its return to idle before the next start.
                    busy_o <= 1'b0;
                    state  <= SEQ_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Directed self-checking bench for mm_job_sequencer: single job, back-to-back
// queueing, bad descriptors, timeout, coincident events and mid-job reset.
module tb_mm_job_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [15:0] cmd_base_addra_i;
    logic [15:0] cmd_base_addrb_i;
    logic [15:0] cmd_base_addrp_i;
    logic [3:0]  cmd_k_i;
    logic [3:0]  cmd_m_i;
    logic [3:0]  cmd_n_i;
    logic        start_o;
    logic [15:0] base_addra_o;
    logic [15:0] base_addrb_o;
    logic [15:0] base_addrp_o;
    logic [3:0]  k_o;
    logic [3:0]  m_o;
    logic [3:0]  n_o;
    logic        valid_i;
    logic [15:0] timeout_i;
    logic        busy_o;
    logic [2:0]  pending_o;
    logic [7:0]  done_cnt_o;
    logic        irq_o;
    logic [1:0]  err_o;
    logic        err_clr_i;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic [3:0]  k;
        logic [3:0]  n;
        int          cyc;
    } start_rec_t;

    start_rec_t start_q[$];
    int         valid_q[$];
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;

    mm_job_sequencer #(
        .ADDR_WIDTH (16),
        .DEPTH      (4),
        .TMO_W      (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_base_addra_i (cmd_base_addra_i),
        .cmd_base_addrb_i (cmd_base_addrb_i),
        .cmd_base_addrp_i (cmd_base_addrp_i),
        .cmd_k_i          (cmd_k_i),
        .cmd_m_i          (cmd_m_i),
        .cmd_n_i          (cmd_n_i),
        .start_o          (start_o),
        .base_addra_o     (base_addra_o),
        .base_addrb_o     (base_addrb_o),
        .base_addrp_o     (base_addrp_o),
        .k_o              (k_o),
        .m_o              (m_o),
        .n_o              (n_o),
        .valid_i          (valid_i),
        .timeout_i        (timeout_i),
        .busy_o           (busy_o),
        .pending_o        (pending_o),
        .done_cnt_o       (done_cnt_o),
        .irq_o            (irq_o),
        .err_o            (err_o),
        .err_clr_i        (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Log every start pulse and completion pulse with the cycle it occurred in.
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (!rst_i) begin
            if (start_o === 1'b1)
                start_q.push_back('{base_addra_o, base_addrb_o, base_addrp_o, k_o, n_o, cyc});
            if (valid_i === 1'b1)
                valid_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] p, input logic [3:0] k,
                                 input logic [3:0] m, input logic [3:0] n);
        cmd_valid_i      = v;
        cmd_base_addra_i = a;
        cmd_base_addrb_i = b;
        cmd_base_addrp_i = p;
        cmd_k_i          = k;
        cmd_m_i          = m;
        cmd_n_i          = n;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
            $error("[TB] comparison %s did not match", tag);
        end
    endtask

    task automatic waitStart(input string tag, input int budget);
        int n = 0;
        while (start_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(start_o), 32'd1);
    endtask

    initial begin
        int sbase;
        int vbase;
        int nstart;

        rst_i     = 1'b1;
        valid_i   = 1'b0;
        err_clr_i = 1'b0;
        timeout_i = 16'd0;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        #2;
        checkOutput("rst_ready",   32'(cmd_ready_o), 32'd1);
        checkOutput("rst_pending", 32'(pending_o),   32'd0);
        checkOutput("rst_start",   32'(start_o),     32'd0);
        checkOutput("rst_busy",    32'(busy_o),      32'd0);
        checkOutput("rst_done",    32'(done_cnt_o),  32'd0);
        checkOutput("rst_err",     32'(err_o),       32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Single job: handshake cycle 0, start in cycle 2, valid 20 cycles after start.
        applyStimulus(1'b1, 16'h000, 16'h100, 16'h200, 4'd4, 4'd4, 4'd4);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        checkOutput("single_c1_pending", 32'(pending_o), 32'd1);
        checkOutput("single_c1_start",   32'(start_o),   32'd0);
        tick();
        checkOutput("single_c2_start", 32'(start_o),      32'd1);
        checkOutput("single_c2_busy",  32'(busy_o),       32'd1);
        checkOutput("single_c2_addrb", 32'(base_addrb_o), 32'h100);
        checkOutput("single_c2_k",     32'(k_o),          32'd4);
        tick();
        checkOutput("single_c3_start",   32'(start_o),   32'd0);
        checkOutput("single_c3_pending", 32'(pending_o), 32'd0);
        for (int i = 0; i < 19; i++) tick();
        checkOutput("single_c22_addrp", 32'(base_addrp_o), 32'h200);
        checkOutput("single_c22_n",     32'(n_o),          32'd4);
        checkOutput("single_c22_irq",   32'(irq_o),        32'd0);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checkOutput("single_gap_irq",  32'(irq_o),      32'd1);
        checkOutput("single_gap_done", 32'(done_cnt_o), 32'd1);
        checkOutput("single_gap_busy", 32'(busy_o),     32'd1);
        tick();
        checkOutput("single_idle_irq",   32'(irq_o),        32'd0);
        checkOutput("single_idle_busy",  32'(busy_o),       32'd0);
        checkOutput("single_idle_err",   32'(err_o),        32'd0);
        checkOutput("single_idle_addrp", 32'(base_addrp_o), 32'h200);
        tick();

        // Back-to-back: five jobs into a four-entry FIFO.
        sbase = start_q.size();
        vbase = valid_q.size();
        for (int j = 0; j < 5; j++) begin
            checkOutput("b2b_ready_before_push", 32'(cmd_ready_o), 32'd1);
            applyStimulus(1'b1, 16'h1000 + 16'(j), 16'h2000 + 16'(j*16), 16'h3000 + 16'(j),
                          4'(j+1), 4'(j+2), 4'(15-j));
            tick();
        end
        checkOutput("b2b_full_pending", 32'(pending_o),   32'd4);
        checkOutput("b2b_full_ready",   32'(cmd_ready_o), 32'd0);
        applyStimulus(1'b1, 16'hdead, 16'hbeef, 16'h0bad, 4'd0, 4'd1, 4'd1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        checkOutput("b2b_full_nopush", 32'(pending_o), 32'd4);
        checkOutput("b2b_full_noerr",  32'(err_o),     32'd0);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int j = 1; j < 5; j++) begin
            waitStart("b2b_start_seen", 20);
            tick();
            tick();
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
        end
        checkOutput("b2b_last_irq",  32'(irq_o),      32'd1);
        checkOutput("b2b_last_done", 32'(done_cnt_o), 32'd6);
        tick();
        checkOutput("b2b_end_busy",    32'(busy_o),    32'd0);
        checkOutput("b2b_end_pending", 32'(pending_o), 32'd0);
        checkOutput("b2b_start_count", 32'(start_q.size() - sbase), 32'd5);
        for (int j = 0; j < 5; j++) begin
            checkOutput("b2b_order_a", 32'(start_q[sbase+j].a), 32'h1000 + 32'(j));
            checkOutput("b2b_order_k", 32'(start_q[sbase+j].k), 32'(j+1));
            checkOutput("b2b_order_n", 32'(start_q[sbase+j].n), 32'(15-j));
        end
        for (int j = 0; j < 4; j++)
            checkOutput("b2b_valid_to_start", 32'(start_q[sbase+j+1].cyc - valid_q[vbase+j]), 32'd3);

        // Bad descriptor is dropped and flagged; clear afterwards.
        nstart = start_q.size();
        applyStimulus(1'b1, 16'h4000, 16'h4100, 16'h4200, 4'd0, 4'd3, 4'd3);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        checkOutput("bad_err",     32'(err_o),     32'b01);
        checkOutput("bad_pending", 32'(pending_o), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("bad_nostart", 32'(start_q.size() - nstart), 32'd0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checkOutput("bad_cleared", 32'(err_o), 32'd0);

        // Timeout of 10 with a second job queued; clear coincides with the timeout set.
        timeout_i = 16'd10;
        applyStimulus(1'b1, 16'h5000, 16'h5100, 16'h5200, 4'd2, 4'd2, 4'd2);
        tick();
        applyStimulus(1'b1, 16'h6000, 16'h6100, 16'h6200, 4'd3, 4'd3, 4'd3);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        checkOutput("tmo_a_start", 32'(start_o),      32'd1);
        checkOutput("tmo_a_addr",  32'(base_addra_o), 32'h5000);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("tmo_before_err", 32'(err_o),  32'd0);
        checkOutput("tmo_before_busy", 32'(busy_o), 32'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checkOutput("tmo_err_set_wins", 32'(err_o),      32'b10);
        checkOutput("tmo_no_irq",       32'(irq_o),      32'd0);
        checkOutput("tmo_done_same",    32'(done_cnt_o), 32'd6);
        tick();
        checkOutput("tmo_idle_busy", 32'(busy_o), 32'd0);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checkOutput("stray_no_irq",  32'(irq_o),        32'd0);
        checkOutput("stray_done",    32'(done_cnt_o),   32'd6);
        checkOutput("tmo_b_start",   32'(start_o),      32'd1);
        checkOutput("tmo_b_addr",    32'(base_addra_o), 32'h6000);
        for (int i = 0; i < 10; i++) tick();
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checkOutput("coinc_irq",  32'(irq_o),      32'd1);
        checkOutput("coinc_done", 32'(done_cnt_o), 32'd7);
        checkOutput("coinc_err",  32'(err_o),      32'b10);
        tick();
        checkOutput("coinc_idle_busy", 32'(busy_o), 32'd0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checkOutput("tmo_cleared", 32'(err_o), 32'd0);
        timeout_i = 16'd0;

        // Reset in the middle of a WAIT with two further jobs queued.
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 16'h7000 + 16'(j), 16'h7100, 16'h7200, 4'd5, 4'd5, 4'd5);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        checkOutput("prerst_pending", 32'(pending_o), 32'd2);
        checkOutput("prerst_busy",    32'(busy_o),    32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_ready",   32'(cmd_ready_o),  32'd1);
        checkOutput("midrst_pending", 32'(pending_o),    32'd0);
        checkOutput("midrst_done",    32'(done_cnt_o),   32'd0);
        checkOutput("midrst_busy",    32'(busy_o),       32'd0);
        checkOutput("midrst_addra",   32'(base_addra_o), 32'd0);
        checkOutput("midrst_k",       32'(k_o),          32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        nstart = start_q.size();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("postrst_nostart", 32'(start_q.size() - nstart), 32'd0);
        checkOutput("postrst_pending", 32'(pending_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
